// File: rtl/seg7_scan_ctrl_if.sv
// Display-register side of the 7-segment scan controller: captured hex word,
// decimal points, brightness and the driven SEG/AN pins.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] LedData;
    logic [NUM_DIGITS-1:0]   dp;
    logic [3:0]              bright;
    logic                    update;
    logic [7:0]              SEG;
    logic [7:0]              AN;
    logic                    frame_start;

    modport master (
        output LedData, dp, bright, update,
        input  SEG, AN, frame_start
    );

    modport slave (
        input  LedData, dp, bright, update,
        output SEG, AN, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with double buffering, dead time and PWM dimming.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SLOT_CYCLES = 5000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic            CLK,
    input  logic            RST,
    seg7_scan_ctrl_if.slave bus
);
    localparam int              SC_W       = $clog2(SLOT_CYCLES);
    localparam int              DW         = 4 * NUM_DIGITS;
    localparam logic [SC_W-1:0] SLOT_LAST  = SC_W'(SLOT_CYCLES - 1);
    localparam logic [SC_W-1:0] DEAD_END   = SC_W'(DEAD_CYCLES);
    localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [SC_W-1:0]       r_slot_cnt;
    logic [2:0]            r_digit;
    logic [3:0]            r_pwm_cnt;
    logic [DW-1:0]         r_stage;
    logic [NUM_DIGITS-1:0] r_stage_dp;
    logic                  r_pending;
    logic [DW-1:0]         r_shadow;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [7:0]            r_seg;
    logic [7:0]            r_an;
    logic                  r_frame_start;

    logic        w_slot_wrap;
    logic        w_frame_wrap;
    logic        w_dead;
    logic [31:0] w_shadow_pad;
    logic [7:0]  w_dp_pad;
    logic [3:0]  w_nibble;
    logic [7:0]  w_blank;
    logic [7:0]  w_seg_next;
    logic [7:0]  w_an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            4'hF:    seg_decode = 7'b0001110;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_digit == DIGIT_LAST);
    assign w_dead       = (r_slot_cnt < DEAD_END);
    // Zero-padding to the full 8-digit width lets the digit index select without range checks.
    assign w_shadow_pad = 32'(r_shadow);
    assign w_dp_pad     = 8'(r_shadow_dp);
    assign w_nibble     = w_shadow_pad[{r_digit, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    logic w_zero_above;

    // A digit goes dark when it and all higher digits are zero and its own dp is off.
    always_comb begin
        w_blank      = 8'h00;
        w_zero_above = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            w_zero_above = w_zero_above && (w_shadow_pad[4*k +: 4] == 4'h0);
            w_blank[k]   = w_zero_above && !w_dp_pad[k];
        end
    end
`else
    assign w_blank = 8'h00;
`endif

    // Segment pattern for the digit currently selected by the scan counter.
    always_comb begin
        w_seg_next = {~w_dp_pad[r_digit], seg_decode(w_nibble)};
    end

    // Anode drive: dark during dead time, otherwise lit for the PWM on-phase.
    always_comb begin
        w_an_next = 8'hFF;
        if (!w_dead && (r_pwm_cnt <= bus.bright) && !w_blank[r_digit]) begin
            w_an_next[r_digit] = 1'b0;
        end else begin
            w_an_next = 8'hFF;
        end
    end

    // Scan counters, staging/shadow buffers and the registered pin drivers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_slot_cnt    <= {SC_W{1'b0}};
            r_digit       <= 3'd0;
            r_pwm_cnt     <= 4'h0;
            r_stage       <= {DW{1'b0}};
            r_stage_dp    <= {NUM_DIGITS{1'b0}};
            r_pending     <= 1'b0;
            r_shadow      <= {DW{1'b0}};
            r_shadow_dp   <= {NUM_DIGITS{1'b0}};
            r_seg         <= 8'hFF;
            r_an          <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            if (w_slot_wrap) begin
                r_slot_cnt <= {SC_W{1'b0}};
                r_digit    <= (r_digit == DIGIT_LAST) ? 3'd0 : r_digit + 3'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + SC_W'(1);
            end

            r_pwm_cnt <= w_dead ? 4'h0 : r_pwm_cnt + 4'h1;

            // An update landing on the boundary bypasses staging so it shows in the new frame.
            if (w_frame_wrap && bus.update) begin
                r_shadow    <= bus.LedData;
                r_shadow_dp <= bus.dp;
                r_pending   <= 1'b0;
            end else if (w_frame_wrap && r_pending) begin
                r_shadow    <= r_stage;
                r_shadow_dp <= r_stage_dp;
                r_pending   <= 1'b0;
            end else if (bus.update) begin
                r_stage    <= bus.LedData;
                r_stage_dp <= bus.dp;
                r_pending  <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end

            r_seg         <= w_seg_next;
            r_an          <= w_an_next;
            r_frame_start <= (r_slot_cnt == {SC_W{1'b0}}) && (r_digit == 3'd0);
        end
    end

    assign bus.SEG         = r_seg;
    assign bus.AN          = r_an;
    assign bus.frame_start = r_frame_start;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed 7-segment display controller for the board display path. Drives up to 8 common-anode digits from a packed hex word. Adds the following over the fixed 8-digit driver:
- configurable digit count and scan rate;
- per-digit decimal points;
- tear-free double-buffered updates at frame boundaries;
- inter-digit dead time against ghosting;
- 16-level brightness PWM;
- optional leading-zero blanking.

It sits between the CPU's display register (LedData) and the FPGA SEG/AN pins.

## Interface
- NUM_DIGITS, 8, number of scanned digits, legal 1..8
- SLOT_CYCLES, 5000, CLK cycles per digit slot, legal >= DEAD_CYCLES+16
- DEAD_CYCLES, 16, cycles at start of every slot with all anodes off, legal 0..SLOT_CYCLES-16

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- LedData  in  4*NUM_DIGITS  hex nibbles, digit k = LedData[4k+3:4k], digit 0 rightmost
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full
- update  in  1  one-cycle request to capture LedData/dp
- SEG  out  8  active-low segments, SEG[6:0] = g..a, SEG[7] = dp
- AN  out  8  active-low anode selects, AN[k] = digit k, bits >= NUM_DIGITS held 1
- frame_start  out  1  one-cycle pulse at start of digit-0 slot

## Operation
Registers:
- slot_cnt: 0..SLOT_CYCLES-1
- digit: 0..NUM_DIGITS-1
- pwm_cnt: 4 bits
- stage / stage_dp: staging buffer
- pending: staging buffer holds unconsumed data
- shadow / shadow_dp: displayed copy

Scan behaviour:
- slot_cnt increments every cycle. At SLOT_CYCLES-1 it wraps to 0 and digit advances, wrapping NUM_DIGITS-1 -> 0.
- The frame boundary is the cycle where slot_cnt and digit both wrap to 0.
- Dead window (slot_cnt < DEAD_CYCLES): AN = 8'hFF, pwm_cnt held 0.
- Active window: pwm_cnt increments every cycle, wrapping 15 -> 0. AN[digit] = 0 iff pwm_cnt <= bright and the digit is not blanked; all other AN bits are 1.

Buffering:
- update captures LedData/dp into stage and sets pending.
- At the frame boundary with pending set, stage is copied to shadow and pending is cleared.
- update on the frame-boundary cycle: shadow loads LedData/dp directly and pending is cleared.
- Multiple updates within one frame: the last one wins.

Decode is from shadow nibble[digit], active-low gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
- SEG[7] = ~shadow_dp[digit].

## Timing
- SEG, AN and frame_start are registered and lag the internal counters by exactly 1 cycle.
- Reset values:
  - SEG = 8'hFF, AN = 8'hFF, frame_start = 0;
  - all counters, stage, shadow and pending = 0.
- RST asserted mid-frame forces the outputs to their reset values immediately (asynchronously). The internal registers clear with them. The scan restarts at digit 0, slot_cnt 0 on the first edge after RST deasserts.
- Frame period = NUM_DIGITS*SLOT_CYCLES cycles.
- frame_start pulses once per frame, starting with the first frame after reset.
- Latency from update to display:
  - new data appears in the first digit-0 slot after the next frame boundary;
  - worst case one frame plus 1 cycle.
- bright is sampled every cycle. A change takes effect on the next active-window cycle; no glitch protection is required.
- SEG is valid during the dead window. Its value is don't-care for display, but it must equal the decode of the current digit.

## Configuration
- SEG7_LZB_EN defined:
  - Digit k (k >= 1) is blanked when shadow nibbles k..NUM_DIGITS-1 are all 0 and shadow_dp[k] = 0.
  - A blanked digit's AN stays 1 for its whole slot. Slot timing is unchanged.
  - Digit 0 is never blanked.
- SEG7_LZB_EN undefined: no digit is ever blanked.

## Test plan
- Reset mid-frame with AN active: RST=1 -> SEG=8'hFF and AN=8'hFF in the same cycle. After release, frame_start fires and digit 0 is scanned first.
- Basic scan: NUM_DIGITS=8, SLOT_CYCLES=64, DEAD_CYCLES=4, bright=15, LedData=32'h12345678 with update, dp=8'h01.
  - After the next frame_start: AN=8'hFE with SEG=8'h00 (digit 0 shows 8, dp lit) for 60 cycles after 4 cycles of AN=8'hFF.
  - Digit 7 slot: AN=8'h7F, SEG=8'hF9.
- Brightness: bright=3 -> within each active window AN[digit]=0 for exactly 4 of every 16 cycles. With bright=0 -> 1 of every 16.
- Tear-free update:
  - update with 32'hAAAAAAAA mid-frame -> SEG keeps the old pattern until after frame_start, then shows 8'h88.
  - update exactly on the boundary cycle -> new value shown in that same frame.
- Blanking: LedData=32'h00000050, dp=0.
  - With SEG7_LZB_EN: AN[7:2] never 0; digit 1 shows 8'h92, digit 0 shows 8'hC0.
  - Without SEG7_LZB_EN: all 8 digits are scanned.
- Width: NUM_DIGITS=4 -> AN[7:4] constantly 1 and frame_start period = 4*SLOT_CYCLES.
